// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/exec/wb control unit driving MAIN
// Ports: clk, Reset (sync, active-high), Run (start, sampled in IDLE),
//   imem_req/imem_addr/imem_ack/imem_data (instruction fetch handshake),
//   ZF/OF (MAIN flags), Write_Reg/Mem_Write/ALU_OP/R_Addr_A/R_Addr_B/W_Addr/STORAGE_Addr_R
//   (MAIN controls), PC, Halted, Fault (sticky), Fault_Cause (01 illegal, 10 timeout, 11 overflow).
// Option: define OVF_TRAP_EN to trap ADD/SUB overflow instead of writing the result.
module instr_sequencer #(
  parameter int PC_W = 6,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            Run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  input  logic            ZF,
  input  logic            OF,
  output logic            Write_Reg,
  output logic            Mem_Write,
  output logic [2:0]      ALU_OP,
  output logic [4:0]      R_Addr_A,
  output logic [4:0]      R_Addr_B,
  output logic [4:0]      W_Addr,
  output logic [5:0]      STORAGE_Addr_R,
  output logic [PC_W-1:0] PC,
  output logic            Halted,
  output logic            Fault,
  output logic [1:0]      Fault_Cause
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
  state_t state, state_n;
  logic [31:0] ir, ir_n;
  logic [CW-1:0] cnt, cnt_n;
  logic zf_q, zf_n, req_n, wr_n, mw_n, halt_n, fault_n;
  logic [2:0] alu_n;
  logic [1:0] fc_n;
  logic [PC_W-1:0] pc_n;
  logic [3:0] d_ir, d_in;
  logic unused_ir;
  // {legal, alu_op} for an instruction word
  function automatic logic [3:0] dec(input logic [31:0] w);
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h24: dec = 4'b1000;
        6'h25: dec = 4'b1001;
        6'h26: dec = 4'b1010;
        6'h27: dec = 4'b1011;
        6'h20: dec = 4'b1100;
        6'h22: dec = 4'b1101;
        6'h2A: dec = 4'b1110;
        6'h00: dec = 4'b1111;
        default: dec = 4'b0000;
      endcase
      6'h2B, 6'h3F: dec = 4'b1000;
      6'h04: dec = 4'b1101;
      default: dec = 4'b0000;
    endcase
  endfunction
  assign d_ir = dec(ir);
  assign d_in = dec(imem_data);
  // address outputs are fields of the registered IR
  assign R_Addr_A = ir[25:21];
  assign R_Addr_B = ir[20:16];
  assign W_Addr = ir[15:11];
  assign STORAGE_Addr_R = ir[5:0];
  assign imem_addr = PC;
  assign unused_ir = ^ir[10:6];
`ifdef OVF_TRAP_EN
  logic addsub;
  assign addsub = ir[31:26] == 6'h00 && (ir[5:0] == 6'h20 || ir[5:0] == 6'h22);
`else
  logic unused_of;
  assign unused_of = OF;
`endif
  always_comb begin
    state_n = state;
    ir_n = ir;
    cnt_n = cnt;
    zf_n = zf_q;
    pc_n = PC;
    req_n = 1'b0;
    wr_n = 1'b0;
    mw_n = 1'b0;
    alu_n = ALU_OP;
    halt_n = Halted;
    fault_n = Fault;
    fc_n = Fault_Cause;
    case (state)
      S_IDLE: if (Run) begin
        state_n = S_FETCH;
        req_n = 1'b1;
        cnt_n = '0;
      end
      S_FETCH: if (imem_ack) begin
        state_n = S_DECODE;
        ir_n = imem_data;
        alu_n = d_in[2:0];
      end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
        state_n = S_HALT;
        halt_n = 1'b1;
        fault_n = 1'b1;
        fc_n = 2'b10;
      end else begin
        cnt_n = cnt + 1'b1;
        req_n = 1'b1;
      end
      S_DECODE: if (!d_ir[3] || ir[31:26] == 6'h3F) begin
        state_n = S_HALT;
        halt_n = 1'b1;
        fault_n = !d_ir[3];
        fc_n = d_ir[3] ? 2'b00 : 2'b01;
      end else state_n = S_EXEC;
      S_EXEC: begin
        zf_n = ZF;
`ifdef OVF_TRAP_EN
        if (addsub && OF) begin
          state_n = S_HALT;
          halt_n = 1'b1;
          fault_n = 1'b1;
          fc_n = 2'b11;
        end else
`endif
        begin
          state_n = S_WB;
          wr_n = ir[31:26] == 6'h00;
          mw_n = ir[31:26] == 6'h2B;
        end
      end
      S_WB: begin
        state_n = S_FETCH;
        req_n = 1'b1;
        cnt_n = '0;
        pc_n = PC + PC_W'(1) + ((ir[31:26] == 6'h04 && zf_q) ? ir[PC_W-1:0] : '0);
      end
      default: halt_n = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= S_IDLE;
      ir <= '0;
      cnt <= '0;
      zf_q <= 1'b0;
      PC <= RESET_PC;
      imem_req <= 1'b0;
      Write_Reg <= 1'b0;
      Mem_Write <= 1'b0;
      ALU_OP <= '0;
      Halted <= 1'b0;
      Fault <= 1'b0;
      Fault_Cause <= '0;
    end else begin
      state <= state_n;
      ir <= ir_n;
      cnt <= cnt_n;
      zf_q <= zf_n;
      PC <= pc_n;
      imem_req <= req_n;
      Write_Reg <= wr_n;
      Mem_Write <= mw_n;
      ALU_OP <= alu_n;
      Halted <= halt_n;
      Fault <= fault_n;
      Fault_Cause <= fc_n;
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized self-checking bench against a transaction-level model
module tb_instr_sequencer;
  logic clk = 0, Reset = 1, Run = 0, imem_ack = 0, ZF = 0, OF = 0;
  logic [31:0] imem_data = 0;
  logic imem_req, Write_Reg, Mem_Write, Halted, Fault;
  logic [5:0] imem_addr, PC, STORAGE_Addr_R;
  logic [2:0] ALU_OP;
  logic [4:0] R_Addr_A, R_Addr_B, W_Addr;
  logic [1:0] Fault_Cause;
  int errs = 0, checks = 0, m_pc = 0;
  logic [5:0] ftab [8] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h20, 6'h22, 6'h2A, 6'h00};
`ifdef OVF_TRAP_EN
  localparam bit TRAP = 1;
`else
  localparam bit TRAP = 0;
`endif
  wire [36:0] outs = {imem_req, Write_Reg, Mem_Write, ALU_OP, R_Addr_A, R_Addr_B, W_Addr,
                      STORAGE_Addr_R, PC, Halted, Fault, Fault_Cause};
  instr_sequencer dut (.clk(clk), .Reset(Reset), .Run(Run), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data), .ZF(ZF), .OF(OF),
    .Write_Reg(Write_Reg), .Mem_Write(Mem_Write), .ALU_OP(ALU_OP), .R_Addr_A(R_Addr_A),
    .R_Addr_B(R_Addr_B), .W_Addr(W_Addr), .STORAGE_Addr_R(STORAGE_Addr_R), .PC(PC),
    .Halted(Halted), .Fault(Fault), .Fault_Cause(Fault_Cause));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset;
    Reset = 1;
    Run = 1;
    repeat (3) begin
      tick;
      chk("reset_outs", outs, 0);
    end
    Reset = 0;
    Run = 0;
    m_pc = 0;
    tick;
    chk("idle_req", imem_req, 0);
  endtask
  task automatic start;
    Run = 1;
    tick;
    Run = 0;
    chk("start_req", {imem_req, imem_addr}, {1'b1, 6'(m_pc)});
  endtask
  task automatic exec_instr(input logic [31:0] w, input int wt, input logic zf, input logic of);
    int idx = -1;
    bit r, sw, beq, hlt, legal, trap;
    logic [2:0] ealu;
    if (w[31:26] == 0) foreach (ftab[i]) if (ftab[i] == w[5:0]) idx = i;
    r = idx >= 0;
    sw = w[31:26] == 6'h2B;
    beq = w[31:26] == 6'h04;
    hlt = w[31:26] == 6'h3F;
    legal = r || sw || beq || hlt;
    ealu = r ? 3'(idx) : beq ? 3'd5 : 3'd0;
    repeat (wt) begin
      chk("fetch_wait", {imem_req, imem_addr, Write_Reg, Mem_Write}, {1'b1, 6'(m_pc), 2'b00});
      imem_ack = 0;
      tick;
    end
    imem_ack = 1;
    imem_data = w;
    tick;
    imem_ack = 0;
    imem_data = $urandom;
    if (!legal || hlt) begin
      ZF = $urandom;
      tick;
      chk("halt_state", {Halted, Fault, Fault_Cause, PC, imem_req, Write_Reg, Mem_Write},
          {1'b1, !legal, legal ? 2'b00 : 2'b01, 6'(m_pc), 3'b000});
      return;
    end
    chk("decode", {ALU_OP, R_Addr_A, R_Addr_B, W_Addr, STORAGE_Addr_R, imem_req, Write_Reg, Mem_Write},
        {ealu, w[25:21], w[20:16], w[15:11], w[5:0], 3'b000});
    ZF = ~zf;
    OF = ~of;
    tick;
    chk("exec_hold", {ALU_OP, R_Addr_A, R_Addr_B, W_Addr, STORAGE_Addr_R, Write_Reg, Mem_Write},
        {ealu, w[25:21], w[20:16], w[15:11], w[5:0], 2'b00});
    ZF = zf;
    OF = of;
    tick;
    ZF = ~zf;
    OF = ~of;
    trap = TRAP && r && (idx == 4 || idx == 5) && of;
    if (trap) begin
      chk("ovf_trap", {Halted, Fault, Fault_Cause, PC, Write_Reg, Mem_Write},
          {1'b1, 1'b1, 2'b11, 6'(m_pc), 2'b00});
      return;
    end
    chk("wb_strobes", {Write_Reg, Mem_Write, imem_req}, {r, sw, 1'b0});
    tick;
    m_pc = (m_pc + 1 + ((beq && zf) ? int'(w[5:0]) : 0)) % 64;
    chk("next_fetch", {PC, imem_addr, imem_req, Write_Reg, Mem_Write, Halted},
        {6'(m_pc), 6'(m_pc), 1'b1, 3'b000});
  endtask
  task automatic sticky_halt(input logic [1:0] fc);
    imem_ack = 1;
    Run = 1;
    imem_data = 32'h00221820;
    repeat (3) tick;
    imem_ack = 0;
    Run = 0;
    chk("halt_sticky", {Halted, Fault_Cause, PC, imem_req, Write_Reg, Mem_Write},
        {1'b1, fc, 6'(m_pc), 3'b000});
  endtask
  initial begin
    logic [31:0] rnd, w;
    int k;
    do_reset;
    start;
    do_reset;
    tick;
    chk("idle_hold", imem_req, 0);
    start;
    exec_instr(32'h00221820, 0, 0, 0);
    exec_instr(32'h10000003, 1, 1, 0);
    chk("pc_at_5", PC, 5);
    exec_instr(32'h10000003, 2, 1, 0);
    chk("beq_taken", PC, 9);
    exec_instr(32'h10000003, 0, 0, 0);
    chk("beq_not_taken", PC, 10);
    exec_instr(32'hAC020007, 3, 0, 1);
    exec_instr(32'h10000000 | 32'(51), 0, 1, 0);
    chk("pc_at_63", PC, 63);
    exec_instr(32'h00221820, 0, 0, 0);
    chk("pc_wrap", PC, 0);
    repeat (150) begin
      rnd = $urandom;
      k = $urandom_range(0, 2);
      w = k == 0 ? {6'h00, rnd[25:6], ftab[$urandom_range(0, 7)]} :
          k == 1 ? {6'h2B, rnd[25:0]} : {6'h04, rnd[25:0]};
      exec_instr(w, $urandom_range(0, 3), 1'($urandom), TRAP ? 1'b0 : 1'($urandom));
    end
    exec_instr(32'h00221820, 0, 0, 1);
    exec_instr(32'h00221822, 1, 0, 1);
    do_reset;
    start;
    exec_instr(32'hFC000000, 0, 0, 0);
    sticky_halt(2'b00);
    do_reset;
    start;
    exec_instr(32'hF8000000, 0, 0, 0);
    sticky_halt(2'b01);
    do_reset;
    start;
    exec_instr(32'h0000003F, 1, 0, 0);
    do_reset;
    start;
    repeat (15) begin
      chk("timeout_wait", {imem_req, Halted}, 2'b10);
      tick;
    end
    chk("timeout", {Halted, Fault, Fault_Cause, imem_req}, {1'b1, 1'b1, 2'b10, 1'b0});
    sticky_halt(2'b10);
    do_reset;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
